// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg: shared types and access-control encodings for the RAM bus arbiter.
// Provides the arbiter FSM state enum, the master index type and funct3-style
// access size/sign codes carried on ramControl.
package mcu_bus_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef logic master_id_t;
    localparam logic [2:0] CTRL_LB  = 3'b000;
    localparam logic [2:0] CTRL_LH  = 3'b001;
    localparam logic [2:0] CTRL_LW  = 3'b010;
    localparam logic [2:0] CTRL_LBU = 3'b100;
    localparam logic [2:0] CTRL_LHU = 3'b101;
    localparam logic [2:0] CTRL_SB  = 3'b000;
    localparam logic [2:0] CTRL_SH  = 3'b001;
    localparam logic [2:0] CTRL_SW  = 3'b010;
endpackage

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: bundle of both master request channels and the RAM port.
// Master side: m*_req/we/addr/wdata/ctrl/lock in, m*_ready/m*_rdata out.
// RAM side: busWe/busAddr/busWData/ramControl out, busRData in.
// Status: gnt_id (current/last winner), busy (transfer in flight).
// slave = arbiter view, master = environment view.
interface ram_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              m0_req, m0_we, m0_lock, m0_ready;
    logic              m1_req, m1_we, m1_lock, m1_ready;
    logic [ADDR_W-1:0] m0_addr, m1_addr, busAddr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [DATA_W-1:0] busWData, busRData;
    logic [2:0]        m0_ctrl, m1_ctrl, ramControl;
    logic              busWe, gnt_id, busy;
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_ctrl, m0_lock,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_ctrl, m1_lock, busRData,
        output m0_ready, m0_rdata, m1_ready, m1_rdata,
        output busWe, busAddr, busWData, ramControl, gnt_id, busy
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_ctrl, m0_lock,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_ctrl, m1_lock, busRData,
        input  m0_ready, m0_rdata, m1_ready, m1_rdata,
        input  busWe, busAddr, busWData, ramControl, gnt_id, busy
    );
endinterface

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational winner selection for two masters.
// Inputs: i_reqs (request vector), i_last_gnt, i_lock_valid, i_owner, i_burst_cnt.
// Outputs: o_winner, o_grant_valid (any request), o_lock_hold (owner kept by lock).
module rr_arb_pick
    import mcu_bus_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter int BURST_MAX = 4
) (
    input  logic [1:0]       i_reqs,
    input  master_id_t       i_last_gnt,
    input  logic             i_lock_valid,
    input  master_id_t       i_owner,
    input  logic [CNT_W-1:0] i_burst_cnt,
    output master_id_t       o_winner,
    output logic             o_grant_valid,
    output logic             o_lock_hold
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(BURST_MAX);
    logic w_lock_hold;
    assign w_lock_hold   = i_lock_valid && i_reqs[i_owner] && (i_burst_cnt < LIM);
    assign o_lock_hold   = w_lock_hold;
    assign o_grant_valid = |i_reqs;
    // Tie goes to whoever did not win last; a single requester just wins.
    assign o_winner      = w_lock_hold ? i_owner : (&i_reqs ? ~i_last_gnt : i_reqs[1]);
endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master round-robin arbiter with bounded lock for one RAM port.
// Ports: i_clk, i_reset (async, active-high), io_bus (slave modport: both master
// channels, RAM bus, gnt_id, busy). One transfer = IDLE -> ACCESS -> RESP.
module ram_bus_arbiter
    import mcu_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input logic                i_clk,
    input logic                i_reset,
    ram_bus_arbiter_if.slave   io_bus
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    arb_state_t        r_state, w_next;
    logic              r_we, r_lock_valid;
    master_id_t        r_gnt_id, r_last_gnt, w_winner;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_m0_rdata, r_m1_rdata;
    logic [2:0]        r_ctrl;
    logic              w_grant_valid, w_lock_hold;

    rr_arb_pick #(.CNT_W(CNT_W), .BURST_MAX(BURST_MAX)) u_pick (
        .i_reqs        ({io_bus.m1_req, io_bus.m0_req}),
        .i_last_gnt    (r_last_gnt),
        .i_lock_valid  (r_lock_valid),
        .i_owner       (r_gnt_id),
        .i_burst_cnt   (r_burst_cnt),
        .o_winner      (w_winner),
        .o_grant_valid (w_grant_valid),
        .o_lock_hold   (w_lock_hold)
    );

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_state <= ARB_IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == ARB_IDLE)   ? (w_grant_valid ? ARB_ACCESS : ARB_IDLE) :
                 (r_state == ARB_ACCESS) ? ARB_RESP : ARB_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_we         <= 1'b0;
            r_lock_valid <= 1'b0;
            r_gnt_id     <= 1'b0;
            r_last_gnt   <= 1'b1;
            r_burst_cnt  <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ctrl       <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            if (r_state == ARB_IDLE) begin
                if (w_grant_valid) begin
                    r_gnt_id     <= w_winner;
                    r_we         <= w_winner ? io_bus.m1_we    : io_bus.m0_we;
                    r_addr       <= w_winner ? io_bus.m1_addr  : io_bus.m0_addr;
                    r_wdata      <= w_winner ? io_bus.m1_wdata : io_bus.m0_wdata;
                    r_ctrl       <= w_winner ? io_bus.m1_ctrl  : io_bus.m0_ctrl;
                    r_lock_valid <= w_winner ? io_bus.m1_lock  : io_bus.m0_lock;
                    r_burst_cnt  <= w_lock_hold ? r_burst_cnt + CNT_W'(1) : CNT_W'(1);
                end else begin
                    // Nobody requesting means the owner gave the bus up.
                    r_lock_valid <= 1'b0;
                end
            end
            // Read data lands directly in the winner's register so the loser keeps its value.
            if (r_state == ARB_ACCESS) begin
                if (r_gnt_id) r_m1_rdata <= io_bus.busRData;
                else          r_m0_rdata <= io_bus.busRData;
            end
            if (r_state == ARB_RESP) r_last_gnt <= r_gnt_id;
        end
    end

    // Combinational from state so an async reset drops the write strobe at once.
    assign io_bus.busWe      = (r_state == ARB_ACCESS) && r_we;
    assign io_bus.busAddr    = r_addr;
    assign io_bus.busWData   = r_wdata;
    assign io_bus.ramControl = r_ctrl;
    assign io_bus.m0_ready   = (r_state == ARB_RESP) && !r_gnt_id;
    assign io_bus.m1_ready   = (r_state == ARB_RESP) && r_gnt_id;
    assign io_bus.m0_rdata   = r_m0_rdata;
    assign io_bus.m1_rdata   = r_m1_rdata;
    assign io_bus.gnt_id     = r_gnt_id;
    assign io_bus.busy       = (r_state != ARB_IDLE);
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: scoreboard bench with directed master queues and a small RAM.
module tb_ram_bus_arbiter;
    import mcu_bus_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        logic        lock;
    } txn_t;

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  ctrl;
        logic [31:0] rdata;
        logic        chk_other;
        logic [31:0] other;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   pop0 = 0, pop1 = 0;
    txn_t q0[$], q1[$];
    exp_t exq[$];

    ram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16] = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                              32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                              32'h10000008, 32'h10000009, 32'h1000000A, 32'h1000000B,
                              32'h1000000C, 32'h1000000D, 32'h1000000E, 32'h1000000F};
    assign bus.busRData = mem[bus.busAddr[5:2]];
    always @(posedge clk) if (bus.busWe) mem[bus.busAddr[5:2]] <= bus.busWData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic txn_t t(input logic we, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] c, input logic l);
        t.we = we; t.addr = a; t.wdata = d; t.ctrl = c; t.lock = l;
    endfunction

    function automatic exp_t e(input logic id, input logic we, input logic [31:0] a,
                               input logic [2:0] c, input logic [31:0] rd,
                               input logic co, input logic [31:0] ov);
        e.id = id; e.we = we; e.addr = a; e.ctrl = c; e.rdata = rd; e.chk_other = co; e.other = ov;
    endfunction

    // Masters: present queue head, advance on the edge that ends ready.
    initial begin : drv
        {bus.m0_req, bus.m0_we, bus.m0_lock, bus.m1_req, bus.m1_we, bus.m1_lock} = '0;
        {bus.m0_addr, bus.m0_wdata, bus.m1_addr, bus.m1_wdata} = '0;
        {bus.m0_ctrl, bus.m1_ctrl} = '0;
        forever begin
            @(posedge clk); #1;
            if (pop0) begin if (q0.size() != 0) q0.delete(0); pop0 = 0; end
            if (pop1) begin if (q1.size() != 0) q1.delete(0); pop1 = 0; end
            bus.m0_req = (q0.size() != 0);
            bus.m1_req = (q1.size() != 0);
            if (q0.size() != 0) begin
                bus.m0_we = q0[0].we; bus.m0_addr = q0[0].addr; bus.m0_wdata = q0[0].wdata;
                bus.m0_ctrl = q0[0].ctrl; bus.m0_lock = q0[0].lock;
            end
            if (q1.size() != 0) begin
                bus.m1_we = q1[0].we; bus.m1_addr = q1[0].addr; bus.m1_wdata = q1[0].wdata;
                bus.m1_ctrl = q1[0].ctrl; bus.m1_lock = q1[0].lock;
            end
        end
    end

    initial begin : mon
        int   acc_cyc;
        exp_t x;
        acc_cyc = -10;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (bus.busy && !bus.m0_ready && !bus.m1_ready) begin
                    acc_cyc = cyc;
                    if (exq.size() == 0) chk("unexpected_access", 64'(bus.busAddr), 64'hFFFF_FFFF_FFFF_FFFF);
                    else chk("access_fields", 64'({bus.gnt_id, bus.busWe, bus.busAddr, bus.ramControl}),
                             64'({exq[0].id, exq[0].we, exq[0].addr, exq[0].ctrl}));
                end else begin
                    chk("busWe_outside_access", 64'(bus.busWe), 64'd0);
                end
                if (bus.m0_ready || bus.m1_ready) begin
                    if (bus.m0_ready) pop0 = 1;
                    if (bus.m1_ready) pop1 = 1;
                    if (exq.size() == 0) chk("unexpected_ready", 64'({bus.m1_ready, bus.m0_ready}), 64'd0);
                    else begin
                        x = exq[0];
                        exq.delete(0);
                        chk("ready_id", 64'({bus.m1_ready, bus.m0_ready}), x.id ? 64'd2 : 64'd1);
                        chk("latency", 64'(cyc - acc_cyc), 64'd1);
                        if (!x.we) chk("rdata", 64'(x.id ? bus.m1_rdata : bus.m0_rdata), 64'(x.rdata));
                        if (x.chk_other) chk("other_rdata", 64'(x.id ? bus.m0_rdata : bus.m1_rdata), 64'(x.other));
                    end
                end
            end
        end
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (exq.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout pending=%0d required=0", name, exq.size());
            exq.delete(); q0.delete(); q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_ready"}, 64'({bus.m1_ready, bus.m0_ready}), 64'd0);
        chk({name, "_busy_we_gnt"}, 64'({bus.busy, bus.busWe, bus.gnt_id}), 64'd0);
        chk({name, "_addr_ctrl"}, 64'({bus.busAddr, bus.ramControl}), 64'd0);
        chk({name, "_wdata"}, 64'(bus.busWData), 64'd0);
        chk({name, "_rdata"}, {bus.m1_rdata, bus.m0_rdata}, 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int n;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;

        // Tie from reset: alternating 0,1,0,1.
        q0.push_back(t(0, 32'h04, 0, CTRL_LW, 0));
        q0.push_back(t(0, 32'h08, 0, CTRL_LW, 0));
        q1.push_back(t(0, 32'h0C, 0, CTRL_LW, 0));
        q1.push_back(t(0, 32'h14, 0, CTRL_LW, 0));
        exq.push_back(e(0, 0, 32'h04, CTRL_LW, 32'h10000001, 0, 0));
        exq.push_back(e(1, 0, 32'h0C, CTRL_LW, 32'h10000003, 0, 0));
        exq.push_back(e(0, 0, 32'h08, CTRL_LW, 32'h10000002, 0, 0));
        exq.push_back(e(1, 0, 32'h14, CTRL_LW, 32'h10000005, 0, 0));
        wait_done("tie_rr");

        // M0 write then read back.
        q0.push_back(t(1, 32'h10, 32'hDEADBEEF, CTRL_SW, 0));
        q0.push_back(t(0, 32'h10, 0, CTRL_LW, 0));
        exq.push_back(e(0, 1, 32'h10, CTRL_SW, 0, 0, 0));
        exq.push_back(e(0, 0, 32'h10, CTRL_LW, 32'hDEADBEEF, 0, 0));
        wait_done("write_read");

        // M1 locked burst of 4, then M0, then M1 again.
        q1.push_back(t(0, 32'h18, 0, CTRL_LW, 1));
        q1.push_back(t(0, 32'h1C, 0, CTRL_LW, 1));
        q1.push_back(t(0, 32'h20, 0, CTRL_LW, 1));
        q1.push_back(t(0, 32'h24, 0, CTRL_LW, 1));
        q1.push_back(t(0, 32'h28, 0, CTRL_LW, 1));
        q0.push_back(t(0, 32'h2C, 0, CTRL_LW, 0));
        exq.push_back(e(1, 0, 32'h18, CTRL_LW, 32'h10000006, 0, 0));
        exq.push_back(e(1, 0, 32'h1C, CTRL_LW, 32'h10000007, 0, 0));
        exq.push_back(e(1, 0, 32'h20, CTRL_LW, 32'h10000008, 0, 0));
        exq.push_back(e(1, 0, 32'h24, CTRL_LW, 32'h10000009, 0, 0));
        exq.push_back(e(0, 0, 32'h2C, CTRL_LW, 32'h1000000B, 0, 0));
        exq.push_back(e(1, 0, 32'h28, CTRL_LW, 32'h1000000A, 0, 0));
        wait_done("burst_lock");

        // M1 locked, drops req after 2; M0 joins during the first.
        q1.push_back(t(0, 32'h30, 0, CTRL_LW, 1));
        q1.push_back(t(0, 32'h34, 0, CTRL_LW, 1));
        exq.push_back(e(1, 0, 32'h30, CTRL_LW, 32'h1000000C, 0, 0));
        exq.push_back(e(1, 0, 32'h34, CTRL_LW, 32'h1000000D, 0, 0));
        exq.push_back(e(0, 0, 32'h38, CTRL_LW, 32'h1000000E, 0, 0));
        n = 0;
        while (!bus.busy && n < 50) begin @(negedge clk); n++; end
        q0.push_back(t(0, 32'h38, 0, CTRL_LW, 0));
        wait_done("lock_release");

        // Reset during an M1 write access.
        q1.push_back(t(1, 32'h3C, 32'h12345678, CTRL_SW, 0));
        exq.push_back(e(1, 1, 32'h3C, CTRL_SW, 0, 0, 0));
        n = 0;
        while (!bus.busWe && n < 50) begin @(negedge clk); n++; end
        chk("abort_saw_access", 64'(bus.busWe), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busWe_drop", 64'(bus.busWe), 64'd0);
        chk("abort_no_ready", 64'({bus.m1_ready, bus.m0_ready}), 64'd0);
        exq.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        chk("abort_ram_unchanged", 64'(mem[15]), 64'h1000000F);
        chk_reset_vals("abort_rst");
        reset = 1'b0;

        // Tie after reset grants M0; byte write then M1 byte-unsigned read.
        q0.push_back(t(1, 32'h20, 32'h000000AB, CTRL_SB, 0));
        q1.push_back(t(0, 32'h20, 0, CTRL_LBU, 0));
        exq.push_back(e(0, 1, 32'h20, CTRL_SB, 0, 1, 32'h0));
        exq.push_back(e(1, 0, 32'h20, CTRL_LBU, 32'h000000AB, 1, 32'h10000008));
        wait_done("byte_route");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
